// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: FSM state encoding and a width helper
// for counter sizing.
package arith_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        StIdle = ST_IDLE,
        StRun  = ST_RUN,
        StDone = ST_DONE
    } state_e;

    // Bits needed to index n items; never returns 0 so a 1-entry counter still has a bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder; also exposes the carry into its MSB
// so the caller can form the signed-overflow flag.
module chunk_adder #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             c_in,
    output logic [CHUNK-1:0] s,
    output logic             c_out,
    output logic             c_msb_in
);

    logic [CHUNK:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = c_in;
        for (int i = 0; i < int'(CHUNK); i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
    end

    assign c_out    = c[CHUNK];
    assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor: CHUNK bits per cycle, carry held in a
// register between chunks, valid/ready handshakes on operand and result sides.
module chunked_serial_adder
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned KW     = clog2_min1(NCHUNK);

    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("chunked_serial_adder: WIDTH must be a non-zero multiple of CHUNK");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             carry_q, cout_q, ovf_q;
    logic [KW-1:0]    k_q;

    logic [CHUNK-1:0] s_w;
    logic             c_out_w, c_msb_w;
    logic             last_chunk;

    // Operands are shifted right each RUN cycle, so the active chunk is always the low bits.
    chunk_adder #(
        .CHUNK(CHUNK)
    ) u_chunk (
        .a       (a_q[CHUNK-1:0]),
        .b       (b_q[CHUNK-1:0]),
        .c_in    (carry_q),
        .s       (s_w),
        .c_out   (c_out_w),
        .c_msb_in(c_msb_w)
    );

    assign last_chunk = (k_q == KW'(NCHUNK - 1));

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) state_d = StRun;
            end
            StRun: begin
                if (last_chunk) state_d = StDone;
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q     <= a;
                        // Subtract as a + ~b + ~cin: invert b and the borrow here.
                        b_q     <= op_sub ? ~b : b;
                        carry_q <= cin ^ op_sub;
                        k_q     <= '0;
                    end
                end
                StRun: begin
                    a_q     <= a_q >> CHUNK;
                    b_q     <= b_q >> CHUNK;
                    carry_q <= c_out_w;
                    cout_q  <= c_out_w;
                    ovf_q   <= c_out_w ^ c_msb_w;
                    for (int i = 0; i < int'(NCHUNK); i++) begin
                        if (k_q == KW'(i)) sum_q[i*CHUNK +: CHUNK] <= s_w;
                    end
                    k_q <= last_chunk ? '0 : k_q + KW'(1);
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
